// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit holding the HI/LO
// architectural registers. Multiply is shift-add, divide is restoring
// shift-subtract; each takes WIDTH RUN cycles plus one FIX cycle.
// Build option: define MDU_DIV_EN to include the divider datapath. Without
// it, DIVU/DIV complete as one-cycle no-ops that leave HI/LO untouched.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   ma_p;
  logic               neg_q_p;
  logic [2*WIDTH-1:0] prod_p;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

`ifdef MDU_DIV_EN
  logic [WIDTH-1:0]   mb_p;
  logic [WIDTH-1:0]   a_raw_p;
  logic [WIDTH-1:0]   rem_p;
  logic [WIDTH-1:0]   quo_p;
  logic               div_p;
  logic               neg_r_p;
  logic               divz_p;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   sub;
  logic [WIDTH-1:0]   rem_nxt;
`endif

  // Magnitude of a two's-complement operand when the op is signed.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic sgn);
    mag = (sgn && v[WIDTH-1]) ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // Two's-complement negation of a single-width result.
  function automatic logic [WIDTH-1:0] negw(input logic signed [WIDTH-1:0] v);
    negw = (~v) + WIDTH'(1);
  endfunction

  // Two's-complement negation of the double-width product.
  function automatic logic [2*WIDTH-1:0] neg2w(input logic signed [2*WIDTH-1:0] v);
    neg2w = (~v) + (2*WIDTH)'(1);
  endfunction

  assign stall   = busy | start;
  assign mul_sum = {1'b0, prod_p[2*WIDTH-1:WIDTH]} + (prod_p[0] ? {1'b0, ma_p} : '0);
  assign mul_res = neg_q_p ? neg2w(prod_p) : prod_p;

`ifdef MDU_DIV_EN
  assign shifted = {rem_p, quo_p[WIDTH-1]};
  assign ge      = shifted >= {1'b0, mb_p};
  assign sub     = WIDTH'(shifted - {1'b0, mb_p});
  assign rem_nxt = ge ? sub : shifted[WIDTH-1:0];
`endif

  // Final HI/LO values presented during FIX, with sign and special-case fixes.
  always_comb begin
    res_hi = mul_res[2*WIDTH-1:WIDTH];
    res_lo = mul_res[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (div_p) begin
      if (divz_p) begin
        res_hi = a_raw_p;
        res_lo = '1;
      end else begin
        res_hi = neg_r_p ? negw(rem_p) : rem_p;
        res_lo = neg_q_p ? negw(quo_p) : quo_p;
      end
    end
`endif
  end

  // Operand latch at start and one radix-2 iteration per RUN cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      ma_p    <= mag(a, op[0]);
      neg_q_p <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
      prod_p  <= {{WIDTH{1'b0}}, mag(b, op[0])};
`ifdef MDU_DIV_EN
      mb_p    <= mag(b, op[0]);
      a_raw_p <= a;
      div_p   <= op[1];
      neg_r_p <= op[0] & a[WIDTH-1];
      divz_p  <= (b == '0);
      rem_p   <= '0;
      quo_p   <= mag(a, op[0]);
`endif
    end else if (state == RUN) begin
`ifdef MDU_DIV_EN
      if (div_p) begin
        rem_p <= rem_nxt;
        quo_p <= {quo_p[WIDTH-2:0], ge};
      end else begin
        prod_p <= {mul_sum, prod_p[WIDTH-1:1]};
      end
`else
      prod_p <= {mul_sum, prod_p[WIDTH-1:1]};
`endif
    end
  end

  // Control FSM, HI/LO registers and the done/busy handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef MDU_DIV_EN
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
`else
            if (op[1]) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              cnt   <= '0;
            end
`endif
          end else begin
            if (wr_hi) hi <= wd;
            if (wr_lo) lo <= wd;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          hi    <= res_hi;
          lo    <= res_lo;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
